// File: rtl/serial_adder_pkg.sv
// Shared definitions for the serial adder: FSM state encoding and a
// ceiling-log2 helper used to size the slice counter.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Returns ceil(log2(value)); 0 for value <= 1.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result++;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/serial_adder_slice.sv
// adder_slice_v: combinational W-bit ripple adder for one slice of the
// serial adder; c_msb is the carry into the slice MSB, used for overflow.
module adder_slice_v #(
  parameter int W = 1
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co,
  output logic         c_msb
);

  logic [W:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int i = 0; i < W; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end
  end

  assign co    = c[W];
  assign c_msb = c[W-1];

endmodule

// File: rtl/serial_adder_v.sv
// serial_adder_v: multi-cycle WIDTH-bit adder producing BITS_PER_CYCLE bits
// per clock. Define SERIAL_ADDER_SUBTRACT_EN to add the i_sub (A-B) port.
module serial_adder_v
  import serial_adder_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_carry,
`ifdef SERIAL_ADDER_SUBTRACT_EN
  input  logic             i_sub,
`endif
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_s,
  output logic             o_carry,
  output logic             o_ovf
);

  localparam int N    = WIDTH / BITS_PER_CYCLE;
  localparam int CW   = (clog2(N) < 1) ? 1 : clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if (WIDTH < 1 || BITS_PER_CYCLE < 1 || (WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_cfg
    $error("serial_adder_v: BITS_PER_CYCLE must divide WIDTH exactly");
  end

  state_t                    state_q;
  logic [CW-1:0]             cnt_q;
  logic [WIDTH-1:0]          a_q, b_q, res_q, s_q;
  logic                      carry_q, co_q, ovf_q, done_q, busy_q;
  logic [WIDTH-1:0]          b_cap, res_d;
  logic                      c_cap;
  logic [BITS_PER_CYCLE-1:0] slice_s;
  logic                      slice_co, slice_cmsb;
  logic [WIDTH+BITS_PER_CYCLE-1:0] res_cat;

  // Subtraction is A + ~B + 1, so B is inverted and the carry forced at capture.
  always_comb begin
    b_cap = i_b;
    c_cap = i_carry;
`ifdef SERIAL_ADDER_SUBTRACT_EN
    if (i_sub) begin
      b_cap = ~i_b;
      c_cap = 1'b1;
    end
`endif
  end

  adder_slice_v #(.W(BITS_PER_CYCLE)) u_slice (
    .a     (a_q[BITS_PER_CYCLE-1:0]),
    .b     (b_q[BITS_PER_CYCLE-1:0]),
    .ci    (carry_q),
    .s     (slice_s),
    .co    (slice_co),
    .c_msb (slice_cmsb)
  );

  // New sum bits enter at the MSB end, so after N slices the word is aligned.
  assign res_cat = {slice_s, res_q};
  assign res_d   = res_cat[WIDTH+BITS_PER_CYCLE-1:BITS_PER_CYCLE];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      s_q     <= '0;
      co_q    <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            a_q     <= i_a;
            b_q     <= b_cap;
            carry_q <= c_cap;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_RUN;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_RUN: begin
          a_q     <= a_q >> BITS_PER_CYCLE;
          b_q     <= b_q >> BITS_PER_CYCLE;
          carry_q <= slice_co;
          res_q   <= res_d;
          cnt_q   <= cnt_q + CW'(1);
          // On the last slice the slice MSB is the word MSB, giving signed overflow.
          if (cnt_q == LAST) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            s_q     <= res_d;
            co_q    <= slice_co;
            ovf_q   <= slice_cmsb ^ slice_co;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_busy  = busy_q;
  assign o_done  = done_q;
  assign o_s     = s_q;
  assign o_carry = co_q;
  assign o_ovf   = ovf_q;

endmodule

// File: tb/tb_serial_adder_v.sv
// Self-checking bench for serial_adder_v (8/1 and 8/4 configurations);
// subtract cases are included when SERIAL_ADDER_SUBTRACT_EN is defined.
module tb_serial_adder_v;

  typedef struct packed {
    logic [7:0] s;
    logic       co;
    logic       ovf;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst, start, start4, carry, sub;
  logic [7:0] a, b;
  logic       busy, done, co, ovf;
  logic [7:0] s;
  logic       busy4, done4, co4, ovf4;
  logic [7:0] s4;
  exp_t       sb[$];
  exp_t       e4;
  int         checks = 0;
  int         errors = 0;
  int         lat;
  logic       sawDone;

  always #5 clk = ~clk;

  serial_adder_v #(.WIDTH(8), .BITS_PER_CYCLE(1)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_a(a), .i_b(b), .i_carry(carry),
`ifdef SERIAL_ADDER_SUBTRACT_EN
    .i_sub(sub),
`endif
    .o_busy(busy), .o_done(done), .o_s(s), .o_carry(co), .o_ovf(ovf)
  );

  serial_adder_v #(.WIDTH(8), .BITS_PER_CYCLE(4)) dut4 (
    .i_clk(clk), .i_rst(rst), .i_start(start4), .i_a(a), .i_b(b), .i_carry(carry),
`ifdef SERIAL_ADDER_SUBTRACT_EN
    .i_sub(sub),
`endif
    .o_busy(busy4), .o_done(done4), .o_s(s4), .o_carry(co4), .o_ovf(ovf4)
  );

  // Reference: plain 9-bit addition, with subtraction as A + ~B + 1.
  function automatic exp_t model(input logic [7:0] ma, input logic [7:0] mb,
                                 input logic mci, input logic msub);
    exp_t       r;
    logic [7:0] bb;
    logic       cc;
    logic [8:0] full;
    bb    = msub ? ~mb : mb;
    cc    = msub ? 1'b1 : mci;
    full  = {1'b0, ma} + {1'b0, bb} + {8'd0, cc};
    r.s   = full[7:0];
    r.co  = full[8];
    r.ovf = (ma[7] == bb[7]) && (full[7] != ma[7]);
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] sa, input logic [7:0] sbv,
                               input logic sci, input logic ssub);
    a     = sa;
    b     = sbv;
    carry = sci;
    sub   = ssub;
    sb.push_back(model(sa, sbv, sci, ssub));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input int expLat, input int already);
    exp_t e;
    int   l;
    l = already;
    while (done !== 1'b1 && l < 40) begin
      @(negedge clk);
      l++;
    end
    if (sb.size() > 0) e = sb.pop_front();
    else e = 'x;
    check({tag, "_done"}, done, 1'b1);
    check({tag, "_lat"}, l, expLat);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_s"}, s, e.s);
    check({tag, "_carry"}, co, e.co);
    check({tag, "_ovf"}, ovf, e.ovf);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; start4 = 1'b0;
    a = '0; b = '0; carry = 1'b0; sub = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_s", s, 8'h00);
    check("rst_carry", co, 1'b0);
    check("rst_ovf", ovf, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    applyStimulus(8'hFF, 8'h01, 1'b0, 1'b0);
    checkOutput("ff_plus_1", 9, 1);
    @(negedge clk);
    applyStimulus(8'h7F, 8'h01, 1'b0, 1'b0);
    checkOutput("7f_plus_1", 9, 1);
    @(negedge clk);
    applyStimulus(8'h12, 8'h34, 1'b1, 1'b0);
    checkOutput("12_34_ci", 9, 1);
    @(negedge clk);

    // Start pulse with new operands mid-run must be ignored.
    applyStimulus(8'h10, 8'h20, 1'b0, 1'b0);
    @(negedge clk);
    check("held_s", s, 8'h47);
    check("run_busy", busy, 1'b1);
    a = 8'hFF; b = 8'hFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("ignored_start", 9, 3);
    @(negedge clk);

    // Start held through DONE gives a back-to-back second result.
    a = 8'h01; b = 8'h02; carry = 1'b0; start = 1'b1;
    sb.push_back(model(8'h01, 8'h02, 1'b0, 1'b0));
    @(negedge clk);
    a = 8'h03; b = 8'h04;
    sb.push_back(model(8'h03, 8'h04, 1'b0, 1'b0));
    checkOutput("b2b_first", 9, 1);
    @(negedge clk);
    start = 1'b0;
    checkOutput("b2b_second", 9, 1);
    @(negedge clk);

    // Reset landing on slice 3 aborts the operation.
    applyStimulus(8'h55, 8'h66, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sawDone = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (done === 1'b1) sawDone = 1'b1;
      @(negedge clk);
    end
    void'(sb.pop_front());
    check("abort_no_done", sawDone, 1'b0);
    check("abort_s", s, 8'h00);
    check("abort_busy", busy, 1'b0);
    applyStimulus(8'h0F, 8'h01, 1'b0, 1'b0);
    checkOutput("after_reset", 9, 1);
    @(negedge clk);

    // Four bits per cycle: N=2.
    a = 8'hA5; b = 8'h5A; carry = 1'b1; sub = 1'b0;
    e4 = model(8'hA5, 8'h5A, 1'b1, 1'b0);
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    lat = 1;
    while (done4 !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("w4_done", done4, 1'b1);
    check("w4_lat", lat, 3);
    check("w4_s", s4, e4.s);
    check("w4_carry", co4, e4.co);
    check("w4_ovf", ovf4, e4.ovf);
    @(negedge clk);

`ifdef SERIAL_ADDER_SUBTRACT_EN
    applyStimulus(8'h05, 8'h07, 1'b0, 1'b1);
    checkOutput("sub_5_7", 9, 1);
    @(negedge clk);
    applyStimulus(8'h80, 8'h01, 1'b0, 1'b1);
    checkOutput("sub_80_1", 9, 1);
    sub = 1'b0;
    @(negedge clk);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
